// File: rtl/prog_loader_ctrl_pkg.sv
// Shared types and constants for the Minisys program loader.
// State encoding, frame command bytes and byte-lane width.
package loader_pkg;

  typedef enum logic [2:0] {
    RUN,
    IDLE,
    CNT_LO,
    CNT_HI,
    DATA
  } state_t;

  localparam logic [7:0] CMD_IMEM = 8'hA5;
  localparam logic [7:0] CMD_DMEM = 8'h5A;
  localparam int         LANE_W   = 2;

  function automatic logic is_cmd(input logic [7:0] b);
    return (b == CMD_IMEM) || (b == CMD_DMEM);
  endfunction

endpackage

// File: rtl/prog_loader_ctrl_if.sv
// UART-side inputs and memory write-port outputs of the loader.
// No backpressure: the UART strobes and the loader must keep up every cycle.
interface prog_loader_ctrl_if #(
  parameter int ADDR_W = 14
);
  logic              mode_load;
  logic              rx_valid;
  logic [7:0]        rx_byte;
  logic              cpu_rst;
  logic              imem_we;
  logic              dmem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    input  mode_load, rx_valid, rx_byte,
    output cpu_rst, imem_we, dmem_we, mem_addr, mem_wdata, busy, done, err
  );

  modport slave (
    output mode_load, rx_valid, rx_byte,
    input  cpu_rst, imem_we, dmem_we, mem_addr, mem_wdata, busy, done, err
  );
endinterface

// File: rtl/prog_loader_ctrl_rx_word_packer.sv
// Assembles little-endian bytes into 32-bit words; word_valid is combinational
// with the 4th byte so the write can be registered on the same edge.
module rx_word_packer
  import loader_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  din,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [LANE_W-1:0] lane;
  logic [23:0]       shreg;

  // Only the three earlier bytes need storing; the 4th comes straight from din.
  assign word_valid = byte_valid && !clear && (lane == '1);
  assign word       = {din, shreg};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lane  <= '0;
      shreg <= '0;
    end else if (clear) begin
      lane  <= '0;
    end else if (byte_valid) begin
      lane  <= lane + 1'b1;
      shreg <= {din, shreg[23:8]};
    end
  end

endmodule

// File: rtl/prog_loader_ctrl.sv
// Holds the CPU in reset while UART frames are written into imem/dmem.
// Writes are registered on the edge accepting each word's 4th byte.
module prog_loader_ctrl
  import loader_pkg::*;
#(
  parameter int ADDR_W      = 14,
  parameter int TIMEOUT_CYC = 1_000_000
) (
  input logic               clock,
  input logic               reset,
  prog_loader_ctrl_if.master bus
);

  localparam int               TMR_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

  state_t            state;
  logic [15:0]       n_q;
  logic [15:0]       wcnt;
  logic [ADDR_W-1:0] addr;
  logic [TMR_W-1:0]  tmr;
  logic              tgt_imem;

  logic              cpu_rst_q;
  logic              imem_we_q;
  logic              dmem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [31:0]       mem_wdata_q;
  logic              done_q;
  logic              err_q;

  logic              in_frame;
  logic              abort;
  logic              tmo;
  logic              cmd_ok;
  logic              pk_clr;
  logic              pk_vld;
  logic              word_valid;
  logic [31:0]       word;

  // Any code other than RUN/IDLE counts as in-frame so a corrupted state still aborts.
  assign in_frame = (state != RUN) && (state != IDLE);
  assign abort    = in_frame && !bus.mode_load;
  assign tmo      = in_frame && bus.mode_load && !bus.rx_valid && (tmr == TMR_LAST);
  assign cmd_ok   = (state == IDLE) && bus.mode_load && bus.rx_valid && is_cmd(bus.rx_byte);
  assign pk_clr   = cmd_ok || abort || tmo;
  assign pk_vld   = (state == DATA) && bus.mode_load && bus.rx_valid;

  rx_word_packer u_pack (
    .clock      (clock),
    .reset      (reset),
    .clear      (pk_clr),
    .byte_valid (pk_vld),
    .din        (bus.rx_byte),
    .word_valid (word_valid),
    .word       (word)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= RUN;
      cpu_rst_q   <= 1'b1;
      imem_we_q   <= 1'b0;
      dmem_we_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      n_q         <= '0;
      wcnt        <= '0;
      addr        <= '0;
      tmr         <= '0;
      tgt_imem    <= 1'b0;
    end else begin
      imem_we_q <= 1'b0;
      dmem_we_q <= 1'b0;
      // Address advances the cycle after a write; a new command below overrides it.
      if (imem_we_q || dmem_we_q) addr <= addr + 1'b1;

      unique case (state)
        RUN: begin
          cpu_rst_q <= bus.mode_load;
          if (bus.mode_load) state <= IDLE;
        end
        IDLE: begin
          if (!bus.mode_load) begin
            state     <= RUN;
            cpu_rst_q <= 1'b0;
          end else if (cmd_ok) begin
            state    <= CNT_LO;
            tgt_imem <= (bus.rx_byte == CMD_IMEM);
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            addr     <= '0;
            wcnt     <= '0;
            tmr      <= '0;
          end else if (bus.rx_valid) begin
            err_q <= 1'b1;
          end
        end
        default: begin
          if (abort) begin
            state     <= RUN;
            cpu_rst_q <= 1'b0;
            err_q     <= 1'b1;
          end else if (tmo) begin
            state <= IDLE;
            err_q <= 1'b1;
          end else if (!bus.rx_valid) begin
            tmr <= tmr + 1'b1;
          end else begin
            tmr <= '0;
            case (state)
              CNT_LO: begin
                n_q[7:0] <= bus.rx_byte;
                state    <= CNT_HI;
              end
              CNT_HI: begin
                n_q[15:8] <= bus.rx_byte;
                if ({bus.rx_byte, n_q[7:0]} == 16'd0) begin
                  state  <= IDLE;
                  done_q <= 1'b1;
                end else begin
                  state <= DATA;
                end
              end
              default: begin
                if (word_valid) begin
                  imem_we_q   <= tgt_imem;
                  dmem_we_q   <= !tgt_imem;
                  mem_addr_q  <= addr;
                  mem_wdata_q <= word;
                  wcnt        <= wcnt + 16'd1;
                  if (wcnt + 16'd1 == n_q) begin
                    state  <= IDLE;
                    done_q <= 1'b1;
                  end
                end
              end
            endcase
          end
        end
      endcase
    end
  end

  assign bus.cpu_rst   = cpu_rst_q;
  assign bus.imem_we   = imem_we_q;
  assign bus.dmem_we   = dmem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.busy      = in_frame;
  assign bus.done      = done_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_prog_loader_ctrl.sv
// Bench for prog_loader_ctrl: directed table, corner sequences, then random
// frames checked every cycle against a byte-position reference model.
module tb_prog_loader_ctrl;

  localparam int AW  = 4;
  localparam int TMO = 16;

  logic clock;
  logic reset;

  prog_loader_ctrl_if #(.ADDR_W(AW)) bus ();

  prog_loader_ctrl #(.ADDR_W(AW), .TIMEOUT_CYC(TMO)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int nvec = 0;
  int nerr = 0;
  int wr_seen = 0;

  // Reference model state: frame progress as a byte position since the cmd.
  logic        m_prog, m_busy, m_isi, m_done, m_err;
  int          m_pos, m_n, m_idle;
  logic [7:0]  m_buf [4];
  logic        e_cpu_rst, e_ie, e_de;
  logic [31:0] e_addr, e_data;

  typedef struct {
    logic ml; logic vld; logic [7:0] b;
    logic rst; logic ie; logic de; logic [3:0] addr; logic [31:0] data;
    logic busy; logic done; logic err;
  } vec_t;
  vec_t tq[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_prog = 0; m_busy = 0; m_isi = 0; m_done = 0; m_err = 0;
    m_pos = 0; m_n = 0; m_idle = 0;
    e_cpu_rst = 1; e_ie = 0; e_de = 0; e_addr = 0; e_data = 0;
  endtask

  task automatic model_edge(input logic ml, input logic vld, input logic [7:0] b);
    int bi;
    e_ie = 0; e_de = 0;
    if (!m_prog) begin
      m_prog = ml;
    end else if (!ml) begin
      if (m_busy) m_err = 1;
      m_prog = 0; m_busy = 0;
    end else if (m_busy) begin
      if (!vld) begin
        m_idle++;
        if (m_idle == TMO) begin m_busy = 0; m_err = 1; end
      end else begin
        m_idle = 0;
        m_pos++;
        if (m_pos == 1) m_n = int'(b);
        else if (m_pos == 2) begin
          m_n = m_n + int'(b) * 256;
          if (m_n == 0) begin m_busy = 0; m_done = 1; end
        end else begin
          bi = m_pos - 3;
          m_buf[bi % 4] = b;
          if (bi % 4 == 3) begin
            e_ie   = m_isi;
            e_de   = !m_isi;
            e_addr = 32'((bi / 4) % (1 << AW));
            e_data = {m_buf[3], m_buf[2], m_buf[1], m_buf[0]};
            if (bi / 4 + 1 == m_n) begin m_busy = 0; m_done = 1; end
          end
        end
      end
    end else if (vld) begin
      if (b == 8'hA5 || b == 8'h5A) begin
        m_busy = 1; m_pos = 0; m_idle = 0; m_done = 0; m_err = 0;
        m_isi = (b == 8'hA5);
      end else begin
        m_err = 1;
      end
    end
    e_cpu_rst = m_prog;
  endtask

  task automatic check_model();
    chk("cpu_rst", 32'(bus.cpu_rst), 32'(e_cpu_rst));
    chk("imem_we", 32'(bus.imem_we), 32'(e_ie));
    chk("dmem_we", 32'(bus.dmem_we), 32'(e_de));
    chk("busy",    32'(bus.busy),    32'(m_busy));
    chk("done",    32'(bus.done),    32'(m_done));
    chk("err",     32'(bus.err),     32'(m_err));
    if (e_ie || e_de) begin
      chk("mem_addr",  32'(bus.mem_addr), e_addr);
      chk("mem_wdata", bus.mem_wdata,     e_data);
    end
  endtask

  task automatic step(input logic ml, input logic vld, input logic [7:0] b);
    bus.mode_load = ml; bus.rx_valid = vld; bus.rx_byte = b;
    @(posedge clock);
    model_edge(ml, vld, b);
    #1;
    if (bus.imem_we || bus.dmem_we) wr_seen++;
    check_model();
  endtask

  task automatic send(input logic [7:0] b);
    step(1'b1, 1'b1, b);
  endtask

  task automatic add_vec(input logic ml, input logic vld, input logic [7:0] b,
                         input logic rst, input logic ie, input logic de,
                         input logic [3:0] addr, input logic [31:0] data,
                         input logic busy, input logic done, input logic err);
    vec_t v;
    v = '{ml, vld, b, rst, ie, de, addr, data, busy, done, err};
    tq.push_back(v);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] fb[$];
    logic [7:0] cmd;
    int nw, gap;

    // Expected outputs after each edge, starting from RUN with done=err=0.
    add_vec(1,0,8'h00, 1,0,0,0,32'h0,        0,0,0);
    add_vec(1,1,8'hA5, 1,0,0,0,32'h0,        1,0,0);
    add_vec(1,1,8'h02, 1,0,0,0,32'h0,        1,0,0);
    add_vec(1,1,8'h00, 1,0,0,0,32'h0,        1,0,0);
    add_vec(1,1,8'h78, 1,0,0,0,32'h0,        1,0,0);
    add_vec(1,1,8'h56, 1,0,0,0,32'h0,        1,0,0);
    add_vec(1,1,8'h34, 1,0,0,0,32'h0,        1,0,0);
    add_vec(1,1,8'h12, 1,1,0,0,32'h12345678, 1,0,0);
    add_vec(1,1,8'hEF, 1,0,0,0,32'h0,        1,0,0);
    add_vec(1,1,8'hBE, 1,0,0,0,32'h0,        1,0,0);
    add_vec(1,1,8'hAD, 1,0,0,0,32'h0,        1,0,0);
    add_vec(1,1,8'hDE, 1,1,0,1,32'hDEADBEEF, 0,1,0);
    add_vec(1,0,8'h00, 1,0,0,0,32'h0,        0,1,0);
    add_vec(1,1,8'h5A, 1,0,0,0,32'h0,        1,0,0);
    add_vec(1,1,8'h00, 1,0,0,0,32'h0,        1,0,0);
    add_vec(1,1,8'h00, 1,0,0,0,32'h0,        0,1,0);
    add_vec(1,1,8'h33, 1,0,0,0,32'h0,        0,1,1);
    add_vec(1,1,8'h5A, 1,0,0,0,32'h0,        1,0,0);
    add_vec(1,1,8'h01, 1,0,0,0,32'h0,        1,0,0);
    add_vec(1,1,8'h00, 1,0,0,0,32'h0,        1,0,0);
    add_vec(1,1,8'h44, 1,0,0,0,32'h0,        1,0,0);
    add_vec(1,1,8'h33, 1,0,0,0,32'h0,        1,0,0);
    add_vec(1,1,8'h22, 1,0,0,0,32'h0,        1,0,0);
    add_vec(1,1,8'h11, 1,0,1,0,32'h11223344, 0,1,0);
    add_vec(0,0,8'h00, 0,0,0,0,32'h0,        0,1,0);

    // Reset with mode_load low.
    reset = 1'b1;
    bus.mode_load = 1'b0; bus.rx_valid = 1'b0; bus.rx_byte = 8'h00;
    model_reset();
    #12;
    check_model();
    chk("rst_mem_addr",  32'(bus.mem_addr), 32'h0);
    chk("rst_mem_wdata", bus.mem_wdata,     32'h0);
    reset = 1'b0;
    step(1'b0, 1'b0, 8'h00);
    chk("rst_release_cpu_rst", 32'(bus.cpu_rst), 32'h0);

    foreach (tq[i]) begin
      step(tq[i].ml, tq[i].vld, tq[i].b);
      chk($sformatf("tbl%0d_cpu_rst", i), 32'(bus.cpu_rst), 32'(tq[i].rst));
      chk($sformatf("tbl%0d_imem_we", i), 32'(bus.imem_we), 32'(tq[i].ie));
      chk($sformatf("tbl%0d_dmem_we", i), 32'(bus.dmem_we), 32'(tq[i].de));
      chk($sformatf("tbl%0d_busy", i),    32'(bus.busy),    32'(tq[i].busy));
      chk($sformatf("tbl%0d_done", i),    32'(bus.done),    32'(tq[i].done));
      chk($sformatf("tbl%0d_err", i),     32'(bus.err),     32'(tq[i].err));
      if (tq[i].ie || tq[i].de) begin
        chk($sformatf("tbl%0d_addr", i), 32'(bus.mem_addr), 32'(tq[i].addr));
        chk($sformatf("tbl%0d_data", i), bus.mem_wdata,     tq[i].data);
      end
    end

    // Timeout mid-frame: one word written, then 16 idle cycles.
    step(1'b1, 1'b0, 8'h00);
    wr_seen = 0;
    send(8'hA5); send(8'h03); send(8'h00);
    send(8'h01); send(8'h02); send(8'h03); send(8'h04); send(8'h05);
    for (int i = 0; i < TMO - 1; i++) begin
      step(1'b1, 1'b0, 8'h00);
      chk("tmo_wait_err",  32'(bus.err),  32'h0);
      chk("tmo_wait_busy", 32'(bus.busy), 32'h1);
    end
    step(1'b1, 1'b0, 8'h00);
    chk("tmo_err",     32'(bus.err),     32'h1);
    chk("tmo_busy",    32'(bus.busy),    32'h0);
    chk("tmo_cpu_rst", 32'(bus.cpu_rst), 32'h1);
    chk("tmo_writes",  32'(wr_seen),     32'h1);

    // mode_load drops on the same edge as a word's 4th byte.
    send(8'hA5); send(8'h01); send(8'h00);
    send(8'hAA); send(8'hBB); send(8'hCC);
    step(1'b0, 1'b1, 8'hDD);
    chk("abort_imem_we", 32'(bus.imem_we), 32'h0);
    chk("abort_err",     32'(bus.err),     32'h1);
    chk("abort_cpu_rst", 32'(bus.cpu_rst), 32'h0);

    // Asynchronous reset mid-frame, right after a write.
    step(1'b1, 1'b0, 8'h00);
    send(8'h5A); send(8'h05); send(8'h00);
    send(8'h11); send(8'h22); send(8'h33); send(8'h44); send(8'h55);
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_model();
    chk("areset_mem_addr",  32'(bus.mem_addr), 32'h0);
    chk("areset_mem_wdata", bus.mem_wdata,     32'h0);
    #2 reset = 1'b0;

    // Random frames with gaps, near-timeout pauses and mode drops.
    for (int f = 0; f < 50; f++) begin
      fb.delete();
      case ($urandom_range(0, 9))
        0, 1, 2, 3: cmd = 8'hA5;
        4, 5, 6, 7: cmd = 8'h5A;
        default:    cmd = 8'($urandom_range(0, 255));
      endcase
      nw = $urandom_range(0, 20);
      fb.push_back(cmd);
      fb.push_back(8'(nw));
      fb.push_back(($urandom_range(0, 15) == 0) ? 8'h01 : 8'h00);
      for (int i = 0; i < 4 * nw; i++) fb.push_back(8'($urandom_range(0, 255)));
      step(1'b1, 1'b0, 8'h00);
      foreach (fb[i]) begin
        gap = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
        if ($urandom_range(0, 99) == 0) gap = $urandom_range(TMO - 2, TMO + 2);
        for (int g = 0; g < gap; g++) step(1'b1, 1'b0, 8'($urandom_range(0, 255)));
        if ($urandom_range(0, 149) == 0) begin
          step(1'b0, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
          step(1'b1, 1'b1, 8'hA5);
        end
        send(fb[i]);
      end
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) step(1'b1, 1'b0, 8'h00);
    end
    step(1'b0, 1'b0, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
